hazard_forward_ctrl: RTL and testbench
======================================

// Module: hazard_forward_ctrl
// PURPOSE
//  Pipeline hazard/forwarding controller for the 5-stage datapath.
//  - Computes the ALU operand forward selects in ID and registers them into EX; they drive the 4x1 operand muxes.
//  - Detects load-use and multicycle-EX hazards and drives PC/IF-ID/ID-EX write enables, flushes and bubbles.
//  - Counts stall cycles.
// PARAMETERS
//  REG_ADDR_W  5   register-number width
//  MC_LAT      4   EX latency of multicycle ops (mult/div); stall = MC_LAT-1 cycles; MC_LAT=1 -> never stalls
//  CNT_W       16  stall counter width
// PORTS
//  Clk           in   1           clock, rising edge
//  Rst           in   1           reset, synchronous, active-low
//  id_rs,id_rt   in   REG_ADDR_W  source regs of instr in ID
//  id_uses_rs    in   1           ID instr reads rs
//  id_uses_rt    in   1           ID instr reads rt (ALU or store data)
//  id_alusrc     in   1           ID instr ALU operand B = immediate
//  ex_rd         in   REG_ADDR_W  dest reg of instr in EX (ID/EX)
//  ex_regwrite   in   1           EX instr writes register file
//  ex_memread    in   1           EX instr is a load
//  ex_multicycle in   1           EX instr is multicycle
//  mem_rd        in   REG_ADDR_W  dest reg of instr in MEM (EX/MEM)
//  mem_regwrite  in   1           MEM instr writes register file
//  branch_taken  in   1           taken branch/jump resolved in EX
//  pc_write      out  1           PC load enable
//  ifid_write    out  1           IF/ID load enable
//  ifid_flush    out  1           IF/ID <- NOP
//  idex_write    out  1           ID/EX load enable
//  idex_bubble   out  1           ID/EX <- NOP (control zeroed)
//  exmem_bubble  out  1           EX/MEM <- NOP
//  fwd_a_sel     out  2           ALU A mux select: 00 reg, 01 EX/MEM, 10 MEM/WB
//  fwd_b_sel     out  2           ALU B mux select: same encoding; 00 + ALUSrc -> imm
//  stall_cnt     out  CNT_W       saturating count of stall cycles
// BEHAVIOUR
//  - Reset (Rst=0 at edge): state<=S_RUN, mc_cnt<=0, fwd_*_sel<=00, stall_cnt<=0.
//    While Rst=0: pc_write=ifid_write=idex_write=0; ifid_flush=idex_bubble=exmem_bubble=1.
//  - Reset mid-stall abandons the stall; no pending state survives.
//  - Forward calc, per operand X in {rs,rt}:
//    - 01 if ex_regwrite & ex_rd!=0 & ex_rd==X;
//    - else 10 if mem_regwrite & mem_rd!=0 & mem_rd==X;
//    - else 00.
//    - EX match beats MEM match. Reg 0 never forwards.
//    - fwd_b forced 00 when id_alusrc=1. Code 11 is never produced.
//  - Register-file write-before-read covers WB->ID; not handled here.
//  - load_use = ex_memread & ex_rd!=0 & ((id_uses_rs & ex_rd==id_rs) | (id_uses_rt & ex_rd==id_rt)).
//  - FSM {S_RUN,S_MCBUSY}; outputs combinational from state+inputs. Priority per cycle:
//    1 branch_taken (S_RUN):
//      - ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1, idex_write=1
//      - fwd_*_sel<=00; load_use ignored
//    2 ex_multicycle & MC_LAT>1 (S_RUN):
//      - pc_write=ifid_write=idex_write=0, exmem_bubble=1
//      - fwd held; mc_cnt<=MC_LAT-2; ->S_MCBUSY
//    3 load_use (S_RUN):
//      - pc_write=ifid_write=0, idex_bubble=1
//      - fwd_*_sel<=00; 1-cycle stall. Next cycle the load is in MEM, so recompute yields 10.
//    4 otherwise: all writes 1, no flush/bubble, fwd_*_sel<=computed.
//  - S_MCBUSY:
//    - same hold outputs as item 2
//    - mc_cnt==0 -> release: outputs per S_RUN rules (items 1,3,4) on the current ID instr, ->S_RUN
//    - else mc_cnt--
//    - branch_taken/ex_multicycle ignored until release.
//  - Total multicycle stall = MC_LAT-1 cycles; no re-trigger on release (EX holds a new instr next cycle).
//  - stall_cnt += 1 each cycle pc_write=0 with Rst=1; saturates at all-ones.
//  - Latency: fwd_*_sel valid in the cycle the instr occupies EX (registered on ID->EX advance).
// STRUCTURE
//  - hazard_pkg:
//    - FWD_REG=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10
//    - state enum {S_RUN,S_MCBUSY}
//  - Sub-module fwd_sel_calc: combinational comparator, instantiated twice (rs, rt).
//  - Top holds FSM, mc_cnt, fwd registers, stall_cnt.
// TESTING
//  1 EX add r3, ID sub uses r3 -> next cycle fwd_a_sel=01; no stall.
//  2 MEM writes r5, EX writes r5, ID reads r5 -> 01 (EX wins); ID reads r0 with ex_rd=0 -> 00.
//  3 EX lw r4, ID uses r4 as rs:
//    - 1 cycle pc_write=0, idex_bubble=1, fwd<=00
//    - next ID cycle computes 10; stall_cnt=1.
//  4 ex_multicycle=1, MC_LAT=4 -> pc_write=0 for exactly 3 cycles, exmem_bubble=1, then S_RUN; stall_cnt=3.
//  5 branch_taken with load_use same cycle -> flush+bubble, pc_write=1, no stall, fwd=00.
//  6 Rst=0 during 2nd MCBUSY cycle -> next cycle S_RUN, fwd=00, stall_cnt=0; id_alusrc=1 with rt match -> fwd_b=00.

Source files
------------

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared encodings for the hazard/forwarding controller
package hazard_pkg;

  // ALU operand mux select encodings; 2'b11 is never produced
  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  typedef enum logic [0:0] {
    S_RUN    = 1'b0,
    S_MCBUSY = 1'b1
  } state_t;

endpackage

// File: rtl/fwd_sel_calc.sv
// rtl/fwd_sel_calc.sv - forward select comparator for one ALU source operand
module fwd_sel_calc
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] src,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_regwrite,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_regwrite,
  output logic [1:0]            sel
);

  // Youngest producer wins; register 0 is hardwired and never forwards
  always_comb begin
    sel = FWD_REG;
    if (ex_regwrite && (ex_rd != '0) && (ex_rd == src)) begin
      sel = FWD_EXMEM;
    end else if (mem_regwrite && (mem_rd != '0) && (mem_rd == src)) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// rtl/hazard_forward_ctrl.sv - load-use/multicycle stall FSM, forward registers and stall counter
module hazard_forward_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int MC_LAT     = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  id_alusrc,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_regwrite,
  input  logic                  ex_memread,
  input  logic                  ex_multicycle,
  input  logic [REG_ADDR_W-1:0] mem_rd,
  input  logic                  mem_regwrite,
  input  logic                  branch_taken,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  idex_write,
  output logic                  idex_bubble,
  output logic                  exmem_bubble,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic [CNT_W-1:0]      stall_cnt
);

  // MC_LAT=1 means multicycle ops finish in one EX cycle and never stall
  localparam bit MC_EN = (MC_LAT > 1);
  localparam int MC_W  = (MC_LAT > 2) ? $clog2(MC_LAT - 1) : 1;
  localparam logic [MC_W-1:0] MC_INIT = MC_W'((MC_LAT > 1) ? (MC_LAT - 2) : 0);

  state_t          state, state_next;
  logic [MC_W-1:0] mc_cnt, mc_next;
  logic [1:0]      calc_a, calc_b_raw, calc_b;
  logic [1:0]      fwd_a_next, fwd_b_next;
  logic            load_use;
  logic            run_rules;

  fwd_sel_calc #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_rs (
    .src          (id_rs),
    .ex_rd        (ex_rd),
    .ex_regwrite  (ex_regwrite),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .sel          (calc_a)
  );

  fwd_sel_calc #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_rt (
    .src          (id_rt),
    .ex_rd        (ex_rd),
    .ex_regwrite  (ex_regwrite),
    .mem_rd       (mem_rd),
    .mem_regwrite (mem_regwrite),
    .sel          (calc_b_raw)
  );

  // Operand B comes from the immediate when ALUSrc is set, so no forwarding
  assign calc_b = id_alusrc ? FWD_REG : calc_b_raw;

  assign load_use = ex_memread && (ex_rd != '0) &&
                    ((id_uses_rs && (ex_rd == id_rs)) || (id_uses_rt && (ex_rd == id_rt)));

  // Next state, pipeline enables and next forward selects by hazard priority
  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    idex_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    state_next   = state;
    mc_next      = mc_cnt;
    fwd_a_next   = fwd_a_sel;
    fwd_b_next   = fwd_b_sel;
    run_rules    = 1'b0;

    if (state == S_MCBUSY) begin
      if (mc_cnt == '0) begin
        state_next = S_RUN;
        run_rules  = 1'b1;
      end else begin
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        idex_write   = 1'b0;
        exmem_bubble = 1'b1;
        mc_next      = mc_cnt - MC_W'(1);
      end
    end else if (!branch_taken && ex_multicycle && MC_EN) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_bubble = 1'b1;
      mc_next      = MC_INIT;
      state_next   = S_MCBUSY;
    end else begin
      run_rules = 1'b1;
    end

    // Release from MCBUSY does not re-check ex_multicycle: EX holds a new instr next
    if (run_rules) begin
      if (branch_taken) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        fwd_a_next  = FWD_REG;
        fwd_b_next  = FWD_REG;
      end else if (load_use) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
        fwd_a_next  = FWD_REG;
        fwd_b_next  = FWD_REG;
      end else begin
        fwd_a_next = calc_a;
        fwd_b_next = calc_b;
      end
    end

    if (!Rst) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      exmem_bubble = 1'b1;
    end
  end

  // State, multicycle countdown, forward registers and saturating stall counter
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state     <= S_RUN;
      mc_cnt    <= '0;
      fwd_a_sel <= FWD_REG;
      fwd_b_sel <= FWD_REG;
      stall_cnt <= '0;
    end else begin
      state     <= state_next;
      mc_cnt    <= mc_next;
      fwd_a_sel <= fwd_a_next;
      fwd_b_sel <= fwd_b_next;
      if (!pc_write && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// tb/tb_hazard_forward_ctrl.sv - directed self-checking bench for hazard_forward_ctrl
module tb_hazard_forward_ctrl;

  logic        Clk;
  logic        Rst;
  logic [4:0]  id_rs, id_rt, ex_rd, mem_rd;
  logic        id_uses_rs, id_uses_rt, id_alusrc;
  logic        ex_regwrite, ex_memread, ex_multicycle, mem_regwrite, branch_taken;
  logic        pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_bubble;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [15:0] stall_cnt;

  int n_vec = 0;
  int n_err = 0;

  hazard_forward_ctrl dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_uses_rs    (id_uses_rs),
    .id_uses_rt    (id_uses_rt),
    .id_alusrc     (id_alusrc),
    .ex_rd         (ex_rd),
    .ex_regwrite   (ex_regwrite),
    .ex_memread    (ex_memread),
    .ex_multicycle (ex_multicycle),
    .mem_rd        (mem_rd),
    .mem_regwrite  (mem_regwrite),
    .branch_taken  (branch_taken),
    .pc_write      (pc_write),
    .ifid_write    (ifid_write),
    .ifid_flush    (ifid_flush),
    .idex_write    (idex_write),
    .idex_bubble   (idex_bubble),
    .exmem_bubble  (exmem_bubble),
    .fwd_a_sel     (fwd_a_sel),
    .fwd_b_sel     (fwd_b_sel),
    .stall_cnt     (stall_cnt)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_alusrc = 1'b0;
    ex_rd = 5'd0; ex_regwrite = 1'b0; ex_memread = 1'b0; ex_multicycle = 1'b0;
    mem_rd = 5'd0; mem_regwrite = 1'b0; branch_taken = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b0;
    idle();
    step();
    step();
    n_vec++; if (pc_write !== 1'b0) begin n_err++; $display("FAIL rst_pc_write got %b exp 0", pc_write); end
    n_vec++; if (ifid_write !== 1'b0 || idex_write !== 1'b0) begin n_err++; $display("FAIL rst_writes got %b%b exp 00", ifid_write, idex_write); end
    n_vec++; if ({ifid_flush, idex_bubble, exmem_bubble} !== 3'b111) begin n_err++; $display("FAIL rst_flush got %b exp 111", {ifid_flush, idex_bubble, exmem_bubble}); end
    n_vec++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin n_err++; $display("FAIL rst_fwd got %b exp 0000", {fwd_a_sel, fwd_b_sel}); end
    n_vec++; if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL rst_stall_cnt got %0d exp 0", stall_cnt); end
    Rst = 1'b1;
    #1;
    n_vec++; if ({pc_write, ifid_flush, exmem_bubble} !== 3'b100) begin n_err++; $display("FAIL post_rst_run got %b exp 100", {pc_write, ifid_flush, exmem_bubble}); end
  endtask

  task automatic test_ex_forward();
    idle();
    ex_rd = 5'd3; ex_regwrite = 1'b1;
    id_rs = 5'd3; id_uses_rs = 1'b1; id_rt = 5'd7; id_uses_rt = 1'b1;
    #1;
    n_vec++; if ({pc_write, idex_bubble} !== 2'b10) begin n_err++; $display("FAIL exfwd_nostall got %b exp 10", {pc_write, idex_bubble}); end
    step();
    n_vec++; if (fwd_a_sel !== 2'b01) begin n_err++; $display("FAIL exfwd_a got %b exp 01", fwd_a_sel); end
    n_vec++; if (fwd_b_sel !== 2'b00) begin n_err++; $display("FAIL exfwd_b got %b exp 00", fwd_b_sel); end
    n_vec++; if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL exfwd_cnt got %0d exp 0", stall_cnt); end
  endtask

  task automatic test_ex_priority();
    idle();
    mem_rd = 5'd5; mem_regwrite = 1'b1; ex_rd = 5'd5; ex_regwrite = 1'b1;
    id_rs = 5'd5; id_uses_rs = 1'b1;
    step();
    n_vec++; if (fwd_a_sel !== 2'b01) begin n_err++; $display("FAIL prio_ex_wins got %b exp 01", fwd_a_sel); end
    ex_rd = 5'd6; id_rs = 5'd9; id_rt = 5'd5; id_uses_rt = 1'b1;
    step();
    n_vec++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0010) begin n_err++; $display("FAIL prio_mem_only got %b exp 0010", {fwd_a_sel, fwd_b_sel}); end
    ex_rd = 5'd0; mem_rd = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    step();
    n_vec++; if ({fwd_a_sel, fwd_b_sel} !== 4'b0000) begin n_err++; $display("FAIL prio_reg0 got %b exp 0000", {fwd_a_sel, fwd_b_sel}); end
  endtask

  task automatic test_load_use();
    idle();
    ex_rd = 5'd4; ex_regwrite = 1'b1; ex_memread = 1'b1;
    id_rs = 5'd4; id_uses_rs = 1'b1;
    #1;
    n_vec++; if ({pc_write, ifid_write, idex_bubble, idex_write} !== 4'b0011) begin n_err++; $display("FAIL lu_stall got %b exp 0011", {pc_write, ifid_write, idex_bubble, idex_write}); end
    step();
    n_vec++; if (fwd_a_sel !== 2'b00) begin n_err++; $display("FAIL lu_fwd_zero got %b exp 00", fwd_a_sel); end
    n_vec++; if (stall_cnt !== 16'd1) begin n_err++; $display("FAIL lu_cnt got %0d exp 1", stall_cnt); end
    ex_rd = 5'd0; ex_regwrite = 1'b0; ex_memread = 1'b0;
    mem_rd = 5'd4; mem_regwrite = 1'b1;
    #1;
    n_vec++; if (pc_write !== 1'b1) begin n_err++; $display("FAIL lu_resume got %b exp 1", pc_write); end
    step();
    n_vec++; if (fwd_a_sel !== 2'b10) begin n_err++; $display("FAIL lu_fwd_mem got %b exp 10", fwd_a_sel); end
    n_vec++; if (stall_cnt !== 16'd1) begin n_err++; $display("FAIL lu_cnt_hold got %0d exp 1", stall_cnt); end
  endtask

  task automatic test_multicycle();
    mem_regwrite = 1'b0;
    ex_rd = 5'd8; ex_regwrite = 1'b1; ex_multicycle = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++; if ({pc_write, ifid_write, idex_write, exmem_bubble} !== 4'b0001) begin n_err++; $display("FAIL mc_hold[%0d] got %b exp 0001", i, {pc_write, ifid_write, idex_write, exmem_bubble}); end
      step();
    end
    #1;
    n_vec++; if ({pc_write, exmem_bubble} !== 2'b10) begin n_err++; $display("FAIL mc_release got %b exp 10", {pc_write, exmem_bubble}); end
    n_vec++; if (fwd_a_sel !== 2'b10) begin n_err++; $display("FAIL mc_fwd_held got %b exp 10", fwd_a_sel); end
    step();
    ex_multicycle = 1'b0;
    n_vec++; if (stall_cnt !== 16'd4) begin n_err++; $display("FAIL mc_cnt got %0d exp 4", stall_cnt); end
    n_vec++; if (fwd_a_sel !== 2'b00) begin n_err++; $display("FAIL mc_fwd_recalc got %b exp 00", fwd_a_sel); end
    #1;
    n_vec++; if (pc_write !== 1'b1) begin n_err++; $display("FAIL mc_no_retrigger got %b exp 1", pc_write); end
  endtask

  task automatic test_branch();
    idle();
    ex_rd = 5'd2; ex_regwrite = 1'b1; ex_memread = 1'b1;
    id_rs = 5'd2; id_uses_rs = 1'b1; branch_taken = 1'b1;
    #1;
    n_vec++; if ({ifid_flush, idex_bubble, pc_write, ifid_write, idex_write} !== 5'b11111) begin n_err++; $display("FAIL br_ctrl got %b exp 11111", {ifid_flush, idex_bubble, pc_write, ifid_write, idex_write}); end
    step();
    n_vec++; if (fwd_a_sel !== 2'b00) begin n_err++; $display("FAIL br_fwd got %b exp 00", fwd_a_sel); end
    n_vec++; if (stall_cnt !== 16'd4) begin n_err++; $display("FAIL br_cnt got %0d exp 4", stall_cnt); end
  endtask

  task automatic test_reset_mid_stall();
    idle();
    ex_rd = 5'd3; ex_regwrite = 1'b1; id_rs = 5'd3; id_uses_rs = 1'b1;
    step();
    n_vec++; if (fwd_a_sel !== 2'b01) begin n_err++; $display("FAIL rms_setup got %b exp 01", fwd_a_sel); end
    ex_multicycle = 1'b1;
    step();
    step();
    Rst = 1'b0;
    #1;
    n_vec++; if ({pc_write, ifid_flush} !== 2'b01) begin n_err++; $display("FAIL rms_in_rst got %b exp 01", {pc_write, ifid_flush}); end
    step();
    Rst = 1'b1;
    idle();
    n_vec++; if (fwd_a_sel !== 2'b00) begin n_err++; $display("FAIL rms_fwd got %b exp 00", fwd_a_sel); end
    n_vec++; if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL rms_cnt got %0d exp 0", stall_cnt); end
    #1;
    n_vec++; if ({pc_write, exmem_bubble} !== 2'b10) begin n_err++; $display("FAIL rms_run got %b exp 10", {pc_write, exmem_bubble}); end
  endtask

  task automatic test_alusrc();
    idle();
    ex_rd = 5'd6; ex_regwrite = 1'b1; id_rt = 5'd6; id_uses_rt = 1'b1; id_alusrc = 1'b1;
    step();
    n_vec++; if (fwd_b_sel !== 2'b00) begin n_err++; $display("FAIL alusrc_imm got %b exp 00", fwd_b_sel); end
    id_alusrc = 1'b0;
    step();
    n_vec++; if (fwd_b_sel !== 2'b01) begin n_err++; $display("FAIL alusrc_off got %b exp 01", fwd_b_sel); end
  endtask

  initial begin
    Rst = 1'b0;
    idle();
    test_reset();
    test_ex_forward();
    test_ex_priority();
    test_load_use();
    test_multicycle();
    test_branch();
    test_reset_mid_stall();
    test_alusrc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
